// File: rtl/secure_sib_lockout.sv
// Purpose: key-protected IJTAG SIB; the open request and the key are shifted in and checked on Update; repeated failed opens lock the SIB closed.
// Latency: the scan path is one flop per bit (KEY_WIDTH+1 when closed). ToSelect and Locked change the cycle after the Update edge.
// Backpressure: none; the scan strobes are obeyed on every cycle in which Select is high.
module secure_sib_lockout #(
    parameter int unsigned          KEY_WIDTH = 128,
    parameter logic [KEY_WIDTH-1:0] KEY_VALUE = KEY_WIDTH'(3476123),
    parameter int unsigned          MAX_FAIL  = 3,
    parameter int unsigned          CNT_WIDTH = 2
) (
    input  logic Clock,
    input  logic RstBar,
    input  logic SI,
    input  logic FromSO,
    input  logic ShiftEN,
    input  logic CaptureEN,
    input  logic UpdateEn,
    input  logic Select,
    output logic SO,
    output logic ToSI,
    output logic ToSelect,
    output logic Locked
);

    localparam logic [CNT_WIDTH-1:0] FAIL_LIMIT = CNT_WIDTH'(MAX_FAIL);

    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic                 sib_sr_q, sib_sr_d;
    logic                 sib_upd_q, sib_upd_d;
    logic [CNT_WIDTH-1:0] fail_cnt_q, fail_cnt_d;
    logic                 locked_q, locked_d;

    // The key register plus the incoming SI bit; the top KEY_WIDTH bits are the shifted key.
    // Built one bit wider so that a 1-bit key needs no special case.
    logic [KEY_WIDTH:0]   shift_ext;
    logic [CNT_WIDTH-1:0] fail_inc;

    assign shift_ext = {SI, key_q};
    assign fail_inc  = fail_cnt_q + CNT_WIDTH'(1);

    // Next-state logic. Capture has priority over Shift, and Shift over Update. A deselected SIB holds its state.
    always_comb begin
        key_d      = key_q;
        sib_sr_d   = sib_sr_q;
        sib_upd_d  = sib_upd_q;
        fail_cnt_d = fail_cnt_q;
        locked_d   = locked_q;
        if (Select) begin
            if (CaptureEN) begin
                // Only the lock status is exposed. The stored key never enters the scan path.
                sib_sr_d = sib_upd_q;
                key_d    = '0;
                key_d[0] = locked_q;
            end else if (ShiftEN) begin
                key_d    = shift_ext[KEY_WIDTH:1];
                sib_sr_d = key_q[0];
            end else if (UpdateEn) begin
                if (locked_q) begin
                    sib_upd_d = 1'b0;
                end else if (key_q == KEY_VALUE) begin
                    sib_upd_d  = sib_sr_q;
                    fail_cnt_d = '0;
                end else if (sib_sr_q) begin
                    // A failed open attempt. The counter stops at the limit and never wraps.
                    sib_upd_d = 1'b0;
                    if (fail_cnt_q != FAIL_LIMIT) begin
                        fail_cnt_d = fail_inc;
                    end
                    if (fail_inc == FAIL_LIMIT) begin
                        locked_d = 1'b1;
                    end
                end else begin
                    // A close request without the key is always honoured.
                    sib_upd_d = 1'b0;
                end
            end
        end
    end

    // State registers. The asynchronous reset returns the SIB closed and unlocked, with the counter cleared.
    always_ff @(posedge Clock or negedge RstBar) begin
        if (!RstBar) begin
            key_q      <= '0;
            sib_sr_q   <= 1'b0;
            sib_upd_q  <= 1'b0;
            fail_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            key_q      <= key_d;
            sib_sr_q   <= sib_sr_d;
            sib_upd_q  <= sib_upd_d;
            fail_cnt_q <= fail_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign ToSI     = sib_sr_q;
    assign SO       = sib_upd_q ? FromSO : sib_sr_q;
    assign ToSelect = Select & sib_upd_q;
    assign Locked   = locked_q;

endmodule

// File: tb/tb_secure_sib_lockout.sv
module tb_secure_sib_lockout;

    localparam int          KW    = 8;
    localparam logic [7:0]  KEY   = 8'hA5;
    localparam int          MAXF  = 3;

    logic Clock = 1'b0;
    logic RstBar = 1'b0;
    logic SI = 1'b0, FromSO = 1'b0, ShiftEN = 1'b0, CaptureEN = 1'b0, UpdateEn = 1'b0, Select = 1'b0;
    logic SO, ToSI, ToSelect, Locked;

    int checks = 0;
    int errors = 0;

    // Reference model. The scan path is a FIFO of bits: the front is the SIB bit and the next KW entries are key bits 0..KW-1.
    bit m_q[$];
    bit m_open;
    int m_fails;
    bit m_locked;

    secure_sib_lockout #(
        .KEY_WIDTH(KW), .KEY_VALUE(KEY), .MAX_FAIL(MAXF), .CNT_WIDTH(2)
    ) dut (
        .Clock(Clock), .RstBar(RstBar), .SI(SI), .FromSO(FromSO),
        .ShiftEN(ShiftEN), .CaptureEN(CaptureEN), .UpdateEn(UpdateEn), .Select(Select),
        .SO(SO), .ToSI(ToSI), .ToSelect(ToSelect), .Locked(Locked)
    );

    always #5 Clock = ~Clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i <= KW; i++) m_q.push_back(1'b0);
        m_open   = 1'b0;
        m_fails  = 0;
        m_locked = 1'b0;
    endtask

    task automatic model_step(input bit sel, input bit cap, input bit sh, input bit upd, input bit si);
        logic [7:0] k;
        bit req;
        if (!sel) return;
        if (cap) begin
            bit snap_open;
            bit snap_lock;
            snap_open = m_open;
            snap_lock = m_locked;
            m_q.delete();
            m_q.push_back(snap_open);
            m_q.push_back(snap_lock);
            for (int i = 1; i < KW; i++) m_q.push_back(1'b0);
        end else if (sh) begin
            m_q.push_back(si);
            void'(m_q.pop_front());
        end else if (upd) begin
            for (int i = 0; i < KW; i++) k[i] = m_q[i+1];
            req = m_q[0];
            if (m_locked) m_open = 1'b0;
            else if (k == KEY) begin
                m_open  = req;
                m_fails = 0;
            end else if (req) begin
                m_open  = 1'b0;
                m_fails = m_fails + 1;
                if (m_fails >= MAXF) m_locked = 1'b1;
            end else m_open = 1'b0;
        end
    endtask

    // Applies one clock of strobes. On return the time is 1 unit after the rising edge and the strobes are cleared.
    task automatic do_op(input bit sel, input bit cap, input bit sh, input bit upd, input bit si, input bit fso);
        Select = sel; CaptureEN = cap; ShiftEN = sh; UpdateEn = upd; SI = si; FromSO = fso;
        @(posedge Clock);
        model_step(sel, cap, sh, upd, si);
        #1;
        CaptureEN = 1'b0; ShiftEN = 1'b0; UpdateEn = 1'b0;
    endtask

    // Shifts the open-request bit first, then the key LSB first.
    task automatic shift_word(input bit open, input logic [7:0] key);
        for (int i = 0; i <= KW; i++) begin
            bit b;
            b = (i == 0) ? open : key[i-1];
            do_op(1'b1, 1'b0, 1'b1, 1'b0, b, FromSO);
        end
    endtask

    task automatic attempt(input bit open, input logic [7:0] key);
        shift_word(open, key);
        do_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, FromSO);
    endtask

    task automatic apply_reset();
        @(negedge Clock);
        RstBar = 1'b0;
        #2;
        model_reset();
        @(negedge Clock);
        RstBar = 1'b1;
    endtask

    task automatic test_reset();
        Select = 1'b1; FromSO = 1'b1;
        RstBar = 1'b0;
        #3;
        checks++; if (SO !== 1'b0)       begin errors++; $display("FAIL reset_SO got %b exp 0", SO); end
        checks++; if (ToSI !== 1'b0)     begin errors++; $display("FAIL reset_ToSI got %b exp 0", ToSI); end
        checks++; if (ToSelect !== 1'b0) begin errors++; $display("FAIL reset_ToSelect got %b exp 0", ToSelect); end
        checks++; if (Locked !== 1'b0)   begin errors++; $display("FAIL reset_Locked got %b exp 0", Locked); end
        model_reset();
        @(negedge Clock);
        RstBar = 1'b1;
    endtask

    task automatic test_capture_stream();
        do_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i <= KW; i++) begin
            checks++; if (SO !== 1'b0) begin errors++; $display("FAIL capture_stream bit %0d got %b exp 0", i, SO); end
            do_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        checks++; if (ToSelect !== 1'b0 || Locked !== 1'b0)
            begin errors++; $display("FAIL capture_status got %b%b exp 00", ToSelect, Locked); end
    endtask

    task automatic test_open();
        attempt(1'b1, KEY);
        checks++; if (ToSelect !== 1'b1) begin errors++; $display("FAIL open_ToSelect got %b exp 1", ToSelect); end
        checks++; if (ToSI !== 1'b1)     begin errors++; $display("FAIL open_ToSI got %b exp 1", ToSI); end
        FromSO = 1'b0; #1;
        checks++; if (SO !== 1'b0) begin errors++; $display("FAIL open_SO_follow0 got %b exp 0", SO); end
        FromSO = 1'b1; #1;
        checks++; if (SO !== 1'b1) begin errors++; $display("FAIL open_SO_follow1 got %b exp 1", SO); end
    endtask

    task automatic test_close();
        attempt(1'b0, 8'h00);
        checks++; if (ToSelect !== 1'b0) begin errors++; $display("FAIL close_ToSelect got %b exp 0", ToSelect); end
        checks++; if (Locked !== 1'b0)   begin errors++; $display("FAIL close_Locked got %b exp 0", Locked); end
    endtask

    task automatic test_lockout();
        for (int n = 1; n <= MAXF; n++) begin
            bit exp_l;
            attempt(1'b1, 8'h3C);
            exp_l = (n == MAXF);
            checks++; if (Locked !== exp_l) begin errors++; $display("FAIL lockout_attempt%0d got %b exp %b", n, Locked, exp_l); end
        end
        attempt(1'b1, KEY);
        checks++; if (ToSelect !== 1'b0) begin errors++; $display("FAIL locked_key_open got %b exp 0", ToSelect); end
        do_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (SO !== 1'b0) begin errors++; $display("FAIL locked_capture_sib got %b exp 0", SO); end
        do_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (SO !== 1'b1) begin errors++; $display("FAIL locked_capture_key0 got %b exp 1", SO); end
    endtask

    task automatic test_async_reset();
        Select = 1'b1; ShiftEN = 1'b1; SI = 1'b1;
        @(posedge Clock);
        #3;
        RstBar = 1'b0;
        #1;
        checks++; if (Locked !== 1'b0)   begin errors++; $display("FAIL async_reset_Locked got %b exp 0", Locked); end
        checks++; if (ToSelect !== 1'b0) begin errors++; $display("FAIL async_reset_ToSelect got %b exp 0", ToSelect); end
        ShiftEN = 1'b0;
        model_reset();
        @(negedge Clock);
        RstBar = 1'b1;
        attempt(1'b1, KEY);
        checks++; if (ToSelect !== 1'b1) begin errors++; $display("FAIL post_reset_open got %b exp 1", ToSelect); end
    endtask

    task automatic test_counter_restart();
        apply_reset();
        attempt(1'b1, 8'h3C);
        attempt(1'b1, 8'h00);
        attempt(1'b1, KEY);
        checks++; if (ToSelect !== 1'b1) begin errors++; $display("FAIL restart_open got %b exp 1", ToSelect); end
        attempt(1'b1, 8'h3C);
        attempt(1'b1, 8'hFF);
        checks++; if (Locked !== 1'b0) begin errors++; $display("FAIL restart_unlocked got %b exp 0", Locked); end
        attempt(1'b1, 8'h5A);
        checks++; if (Locked !== 1'b1) begin errors++; $display("FAIL restart_third_locks got %b exp 1", Locked); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        // The chain holds a valid open request; Shift and Update together must only shift.
        shift_word(1'b1, KEY);
        do_op(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (ToSelect !== 1'b0) begin errors++; $display("FAIL shift_over_update got %b exp 0", ToSelect); end
        // Reload, then drive strobes while deselected; the chain must be untouched.
        apply_reset();
        shift_word(1'b1, KEY);
        do_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (ToSelect !== 1'b0 || SO !== 1'b1)
            begin errors++; $display("FAIL deselected_hold got %b%b exp 01", ToSelect, SO); end
        do_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (ToSelect !== 1'b1) begin errors++; $display("FAIL deselected_then_open got %b exp 1", ToSelect); end
        // Capture beats Update: the update must not happen, so the SIB stays open.
        do_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (ToSelect !== 1'b1) begin errors++; $display("FAIL capture_over_update got %b exp 1", ToSelect); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int it = 0; it < 500; it++) begin
            int r;
            bit exp_so, exp_tosel;
            r = $urandom_range(0, 19);
            if (r < 5) begin
                logic [7:0] k;
                k = ($urandom_range(0, 1) == 1) ? KEY : 8'($urandom);
                attempt(1'($urandom_range(0, 1)), k);
            end else if (r == 19) begin
                apply_reset();
            end else begin
                do_op(($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            exp_so    = m_open ? FromSO : m_q[0];
            exp_tosel = Select & m_open;
            checks++; if (SO !== exp_so)          begin errors++; $display("FAIL rand_SO it %0d got %b exp %b", it, SO, exp_so); end
            checks++; if (ToSI !== m_q[0])        begin errors++; $display("FAIL rand_ToSI it %0d got %b exp %b", it, ToSI, m_q[0]); end
            checks++; if (ToSelect !== exp_tosel) begin errors++; $display("FAIL rand_ToSelect it %0d got %b exp %b", it, ToSelect, exp_tosel); end
            checks++; if (Locked !== m_locked)    begin errors++; $display("FAIL rand_Locked it %0d got %b exp %b", it, Locked, m_locked); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_capture_stream();
        test_open();
        test_close();
        test_lockout();
        test_async_reset();
        test_counter_restart();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
